// File: rtl/bus_map_pkg.sv
// bus_map_pkg: shared region type, MMIO offsets and default bases for bus_responder
package bus_map_pkg;
  typedef enum logic [1:0] {REG_RAM, REG_MMIO, REG_NONE} region_e;
  localparam logic [31:0] DEF_RAM_BASE = 32'h1001_0000;
  localparam logic [31:0] DEF_MMIO_BASE = 32'h1002_0000;
  localparam logic [31:0] MMIO_SPAN = 32'd64;
  localparam logic [5:0] OFF_GPIO_OUT = 6'h00;
  localparam logic [5:0] OFF_GPIO_IN = 6'h04;
  localparam logic [5:0] OFF_COUNT = 6'h10;
  localparam logic [5:0] OFF_COMPARE = 6'h14;
  localparam logic [5:0] OFF_STATUS = 6'h18;
  localparam int ST_PEND = 0;
  localparam int ST_EN = 1;
endpackage

// File: rtl/bus_timer.sv
// bus_timer: free-running cycle counter with compare match and level interrupt
module bus_timer
  import bus_map_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        cmp_we_i,
  input  logic        status_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] cmp_o,
  output logic        irq_pending_o,
  output logic        irq_enable_o,
  output logic        timer_irq_o
);
  logic [31:0] count_q, count_d, cmp_q, cmp_d;
  logic pend_q, pend_d, en_q, en_d;
  // next state: match uses the registered compare, so a compare write only matters from the next cycle; a match beats W1C
  always_comb begin
    count_d = count_we_i ? wdata_i : count_q + 32'd1;
    cmp_d = cmp_we_i ? wdata_i : cmp_q;
    pend_d = (count_q == cmp_q) | (pend_q & ~(status_we_i & wdata_i[ST_PEND]));
    en_d = status_we_i ? wdata_i[ST_EN] : en_q;
  end
  // timer state registers, active-low synchronous reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      cmp_q <= '0;
      pend_q <= 1'b0;
      en_q <= 1'b0;
    end else begin
      count_q <= count_d;
      cmp_q <= cmp_d;
      pend_q <= pend_d;
      en_q <= en_d;
    end
  end
  assign count_o = count_q;
  assign cmp_o = cmp_q;
  assign irq_pending_o = pend_q;
  assign irq_enable_o = en_q;
  assign timer_irq_o = pend_q & en_q;
endmodule

// File: rtl/bus_responder.sv
// bus_responder: memory-bus target decoding word RAM, GPIO and timer regions
module bus_responder
  import bus_map_pkg::*;
#(
  parameter int          RAM_WORDS  = 1024,
  parameter logic [31:0] RAM_BASE   = DEF_RAM_BASE,
  parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE,
  parameter int          GPIO_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           bus_addr,
  input  logic [31:0]           bus_wrdata,
  input  logic                  bus_wren,
  input  logic                  bus_rden,
  output logic [31:0]           bus_rddata,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  timer_irq,
  output logic                  bus_err
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] ram_off, mmio_off, ram_rd_q, mmio_rdata, mmio_rd_q, mmio_rd_d, count, cmp, status;
  logic [5:0] word_off;
  logic [AW-1:0] idx;
  region_e region;
  logic mmio_wr, ram_we, ram_re, rd_acc, pend, en;
  logic rd_ram_q, rd_ram_d, bus_err_q, bus_err_d;
  logic [GPIO_WIDTH-1:0] gpio_out_q, gpio_out_d, sync1_q, sync2_q;
  // address decode, write enables and the read mux captured on an accepted read
  always_comb begin
    ram_off = bus_addr - RAM_BASE;
    mmio_off = bus_addr - MMIO_BASE;
    region = ram_off < RAM_BYTES ? REG_RAM : mmio_off < MMIO_SPAN ? REG_MMIO : REG_NONE;
    word_off = {mmio_off[5:2], 2'b00};
    idx = ram_off[AW+1:2];
    rd_acc = bus_rden && !bus_wren;
    mmio_wr = bus_wren && region == REG_MMIO;
    ram_we = bus_wren && region == REG_RAM;
    ram_re = rd_acc && region == REG_RAM;
    status = '0;
    status[ST_PEND] = pend;
    status[ST_EN] = en;
    mmio_rdata = word_off == OFF_GPIO_OUT ? 32'(gpio_out_q) :
                 word_off == OFF_GPIO_IN  ? 32'(sync2_q) :
                 word_off == OFF_COUNT    ? count :
                 word_off == OFF_COMPARE  ? cmp :
                 word_off == OFF_STATUS   ? status : '0;
    gpio_out_d = mmio_wr && word_off == OFF_GPIO_OUT ? bus_wrdata[GPIO_WIDTH-1:0] : gpio_out_q;
    bus_err_d = bus_err_q | ((bus_wren | bus_rden) && region == REG_NONE);
    rd_ram_d = rd_acc ? region == REG_RAM : rd_ram_q;
    mmio_rd_d = rd_acc ? (region == REG_MMIO ? mmio_rdata : '0) : mmio_rd_q;
  end
  // word RAM with registered read port, contents survive reset
  always_ff @(posedge clk) begin
    if (ram_we) mem[idx] <= bus_wrdata;
    if (ram_re) ram_rd_q <= mem[idx];
  end
  // GPIO, error flag, synchroniser and read-path registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      gpio_out_q <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      bus_err_q <= 1'b0;
      rd_ram_q <= 1'b0;
      mmio_rd_q <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      bus_err_q <= bus_err_d;
      rd_ram_q <= rd_ram_d;
      mmio_rd_q <= mmio_rd_d;
    end
  end
  bus_timer u_timer (
    .clk(clk),
    .rst(rst),
    .count_we_i(mmio_wr && word_off == OFF_COUNT),
    .cmp_we_i(mmio_wr && word_off == OFF_COMPARE),
    .status_we_i(mmio_wr && word_off == OFF_STATUS),
    .wdata_i(bus_wrdata),
    .count_o(count),
    .cmp_o(cmp),
    .irq_pending_o(pend),
    .irq_enable_o(en),
    .timer_irq_o(timer_irq)
  );
  assign bus_rddata = rd_ram_q ? ram_rd_q : mmio_rd_q;
  assign gpio_out = gpio_out_q;
  assign bus_err = bus_err_q;
endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder: directed self-checking bench for bus_responder
module tb_bus_responder;
  localparam logic [31:0] RB = 32'h1001_0000;
  localparam logic [31:0] MB = 32'h1002_0000;
  logic clk = 0, rst = 0, bus_wren = 0, bus_rden = 0;
  logic [31:0] bus_addr = 0, bus_wrdata = 0, r;
  logic [7:0] gpio_in = 0;
  wire [31:0] bus_rddata;
  wire [7:0] gpio_out;
  wire timer_irq, bus_err;
  int pass = 0, total = 0;

  always #5 clk = ~clk;

  bus_responder dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
    .bus_wren(bus_wren), .bus_rden(bus_rden), .bus_rddata(bus_rddata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .timer_irq(timer_irq), .bus_err(bus_err)
  );

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wrdata = d; bus_wren = 1;
    @(negedge clk); bus_wren = 0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a; bus_rden = 1;
    @(posedge clk); #1 d = bus_rddata;
    @(negedge clk); bus_rden = 0;
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (2) @(negedge clk);
    total++; if (bus_rddata !== 32'h0) $display("FAIL reset_rddata got %h want 0", bus_rddata); else pass++;
    total++; if (gpio_out !== 8'h0) $display("FAIL reset_gpio got %h want 0", gpio_out); else pass++;
    total++; if (timer_irq !== 1'b0) $display("FAIL reset_irq got %b want 0", timer_irq); else pass++;
    total++; if (bus_err !== 1'b0) $display("FAIL reset_err got %b want 0", bus_err); else pass++;
    rst = 1;
    @(negedge clk);
  endtask

  task automatic test_ram;
    wr(RB + 32'h8, 32'hCAFE_F00D);
    wr(RB, 32'h11);
    wr(RB + 32'hFFC, 32'h5A5A_5A5A);
    bus_addr = RB + 32'h8; bus_rden = 1;
    #1;
    total++; if (bus_rddata !== 32'h0) $display("FAIL ram_before_edge got %h want 0", bus_rddata); else pass++;
    @(posedge clk); #1;
    total++; if (bus_rddata !== 32'hCAFE_F00D) $display("FAIL ram_latency got %h want cafef00d", bus_rddata); else pass++;
    @(negedge clk); bus_rden = 0;
    rd(RB + 32'hB, r);
    total++; if (r !== 32'hCAFE_F00D) $display("FAIL ram_byte_addr got %h want cafef00d", r); else pass++;
    rd(RB + 32'hFFC, r);
    total++; if (r !== 32'h5A5A_5A5A) $display("FAIL ram_last_word got %h want 5a5a5a5a", r); else pass++;
    rd(RB, r);
    total++; if (r !== 32'h11) $display("FAIL ram_word0 got %h want 11", r); else pass++;
  endtask

  task automatic test_gpio;
    wr(MB, 32'h1A5);
    total++; if (gpio_out !== 8'hA5) $display("FAIL gpio_out got %h want a5", gpio_out); else pass++;
    rd(MB, r);
    total++; if (r !== 32'hA5) $display("FAIL gpio_out_read got %h want a5", r); else pass++;
    gpio_in = 8'h3C;
    rd(MB + 32'h4, r);
    total++; if (r !== 32'h0) $display("FAIL gpio_in_sync1 got %h want 0", r); else pass++;
    rd(MB + 32'h4, r);
    total++; if (r !== 32'h0) $display("FAIL gpio_in_sync2 got %h want 0", r); else pass++;
    rd(MB + 32'h4, r);
    total++; if (r !== 32'h3C) $display("FAIL gpio_in_sync3 got %h want 3c", r); else pass++;
    wr(MB + 32'h4, 32'hFF);
    rd(MB + 32'h4, r);
    total++; if (r !== 32'h3C) $display("FAIL gpio_in_ro got %h want 3c", r); else pass++;
    wr(MB + 32'h8, 32'hFFFF_FFFF);
    rd(MB + 32'h8, r);
    total++; if (r !== 32'h0) $display("FAIL mmio_unused got %h want 0", r); else pass++;
    total++; if (bus_err !== 1'b0) $display("FAIL mmio_unused_err got %b want 0", bus_err); else pass++;
  endtask

  task automatic test_timer;
    wr(MB + 32'h10, 32'd100);
    wr(MB + 32'h14, 32'd10);
    wr(MB + 32'h18, 32'h3);
    wr(MB + 32'h10, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    total++; if (timer_irq !== 1'b0) $display("FAIL irq_early got %b want 0", timer_irq); else pass++;
    @(posedge clk); #1;
    total++; if (timer_irq !== 1'b1) $display("FAIL irq_match got %b want 1", timer_irq); else pass++;
    @(negedge clk);
    rd(MB + 32'h18, r);
    total++; if (r !== 32'h3) $display("FAIL status_set got %h want 3", r); else pass++;
    wr(MB + 32'h18, 32'h3);
    total++; if (timer_irq !== 1'b0) $display("FAIL irq_w1c got %b want 0", timer_irq); else pass++;
    rd(MB + 32'h18, r);
    total++; if (r !== 32'h2) $display("FAIL status_clr got %h want 2", r); else pass++;
    wr(MB + 32'h10, 32'd5);
    rd(MB + 32'h10, r);
    total++; if (r !== 32'd5) $display("FAIL count_load got %h want 5", r); else pass++;
    wr(MB + 32'h10, 32'hFFFF_FFFF);
    rd(MB + 32'h10, r);
    total++; if (r !== 32'hFFFF_FFFF) $display("FAIL count_max got %h want ffffffff", r); else pass++;
    rd(MB + 32'h10, r);
    total++; if (r !== 32'h0) $display("FAIL count_wrap got %h want 0", r); else pass++;
  endtask

  task automatic test_back_to_back;
    wr(MB + 32'h14, 32'd20);
    wr(MB + 32'h10, 32'd17);
    repeat (3) @(negedge clk);
    wr(MB + 32'h18, 32'h3);
    total++; if (timer_irq !== 1'b1) $display("FAIL w1c_vs_match got %b want 1", timer_irq); else pass++;
    rd(MB + 32'h18, r);
    total++; if (r !== 32'h3) $display("FAIL w1c_vs_match_status got %h want 3", r); else pass++;
    wr(MB + 32'h18, 32'h3);
    wr(MB + 32'h10, 32'd50);
    wr(MB + 32'h14, 32'd50);
    repeat (2) @(negedge clk);
    total++; if (timer_irq !== 1'b0) $display("FAIL cmp_write_same_cycle got %b want 0", timer_irq); else pass++;
    rd(RB + 32'h8, r);
    bus_addr = RB + 32'h10; bus_wrdata = 32'h77; bus_wren = 1; bus_rden = 1;
    @(posedge clk); #1;
    total++; if (bus_rddata !== 32'hCAFE_F00D) $display("FAIL wr_rd_hold got %h want cafef00d", bus_rddata); else pass++;
    @(negedge clk); bus_wren = 0; bus_rden = 0;
    rd(RB + 32'h10, r);
    total++; if (r !== 32'h77) $display("FAIL wr_rd_write got %h want 77", r); else pass++;
  endtask

  task automatic test_unmapped;
    rd(32'h0000_0100, r);
    total++; if (r !== 32'h0) $display("FAIL unmapped_read got %h want 0", r); else pass++;
    total++; if (bus_err !== 1'b1) $display("FAIL unmapped_err got %b want 1", bus_err); else pass++;
    wr(RB + 32'h1000, 32'hDEAD);
    rd(RB, r);
    total++; if (r !== 32'h11) $display("FAIL unmapped_write_dropped got %h want 11", r); else pass++;
    total++; if (bus_err !== 1'b1) $display("FAIL err_sticky got %b want 1", bus_err); else pass++;
  endtask

  task automatic test_reset_mid;
    wr(MB, 32'h1A5);
    wr(MB + 32'h10, 32'd30);
    wr(MB + 32'h14, 32'd31);
    repeat (2) @(negedge clk);
    total++; if (timer_irq !== 1'b1) $display("FAIL pre_reset_irq got %b want 1", timer_irq); else pass++;
    bus_addr = RB + 32'h8; bus_rden = 1; rst = 0;
    @(posedge clk); #1;
    total++; if (bus_rddata !== 32'h0) $display("FAIL midrst_rddata got %h want 0", bus_rddata); else pass++;
    total++; if (gpio_out !== 8'h0) $display("FAIL midrst_gpio got %h want 0", gpio_out); else pass++;
    total++; if (timer_irq !== 1'b0) $display("FAIL midrst_irq got %b want 0", timer_irq); else pass++;
    total++; if (bus_err !== 1'b0) $display("FAIL midrst_err got %b want 0", bus_err); else pass++;
    @(negedge clk); bus_rden = 0; rst = 1;
    rd(MB + 32'h10, r);
    total++; if (r !== 32'h0) $display("FAIL midrst_count got %h want 0", r); else pass++;
    rd(RB + 32'h8, r);
    total++; if (r !== 32'hCAFE_F00D) $display("FAIL ram_survives got %h want cafef00d", r); else pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset;
    test_ram;
    test_gpio;
    test_timer;
    test_back_to_back;
    test_unmapped;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
